// File: rtl/patch_assembler.sv
// Serial-to-parallel patch builder: row-major pixel stream in, one full
// PATCH_DIM x PATCH_DIM patch out, with two ping-pong banks so filling overlaps draining.
module patch_assembler #(
   parameter int DATA_W    = 16,
   parameter int PATCH_DIM = 6,
   localparam int PATCH_N  = PATCH_DIM * PATCH_DIM
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_W-1:0]               pix_in,
   input  logic                            pix_valid,
   input  logic                            pix_first,
   output logic                            pix_ready,
   output logic [PATCH_N-1:0][DATA_W-1:0]  pixels_out,
   output logic                            patch_valid,
   input  logic                            patch_ready,
   output logic                            sync_err,
   output logic [15:0]                     patch_count
);

   localparam int IDX_W = $clog2(PATCH_N);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATCH_N - 1);

   logic [PATCH_N-1:0][DATA_W-1:0] bank [2];
   logic [1:0]       full;
   logic             wr_bank;
   logic             rd_bank;
   logic [IDX_W-1:0] wr_idx;
   logic             accept;
   logic             take;

   // pix_ready depends only on state (plus reset), never on the consumer side
   assign pix_ready   = !full[wr_bank] && !reset;
   assign patch_valid = full[rd_bank];
   assign pixels_out  = bank[rd_bank];
   assign accept      = pix_valid && pix_ready;
   assign take        = patch_valid && patch_ready;

   // A fill can only complete into an empty bank and a handoff only frees a
   // full one, so the two full-flag updates below never target the same bank.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank[0]     <= '0;
         bank[1]     <= '0;
         full        <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_idx      <= '0;
         sync_err    <= 1'b0;
         patch_count <= '0;
      end else begin
         if (accept) begin
            if (pix_first) begin
               bank[wr_bank][0] <= pix_in;
               wr_idx           <= IDX_W'(1);
               if (wr_idx != '0) begin
                  sync_err <= 1'b1;
               end
            end else begin
               bank[wr_bank][wr_idx] <= pix_in;
               if (wr_idx == LAST_IDX) begin
                  full[wr_bank] <= 1'b1;
                  wr_bank       <= ~wr_bank;
                  wr_idx        <= '0;
               end else begin
                  wr_idx <= wr_idx + IDX_W'(1);
               end
            end
         end
         if (take) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            patch_count   <= patch_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/patch_assembler.md
# patch_assembler

Upstream feeder for the 6x6 convolution stage. Accepts a serial stream of 16-bit pixels over a valid/ready handshake and assembles them, row-major, into complete 36-pixel patches. Each patch is presented as one wide parallel word with a valid/ready handshake. Two ping-pong patch banks let the next patch fill while the current one is held for the consumer, so the convolution stage sees a new patch every 36 input beats at full throughput.

## Interface
- DATA_W, 16, pixel width in bits
- PATCH_DIM, 6, patch side length; PATCH_N = PATCH_DIM*PATCH_DIM = 36 pixels per patch
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- pix_in  in  DATA_W  input pixel
- pix_valid  in  1  pix_in is valid
- pix_first  in  1  qualifies pix_in as pixel 0 (top-left) of a new patch
- pix_ready  out  1  block accepts pix_in this cycle
- pixels_out  out  PATCH_N x DATA_W  assembled patch; element k = row*PATCH_DIM + col, k=0 top-left
- patch_valid  out  1  pixels_out holds a complete patch
- patch_ready  in  1  consumer takes the patch this cycle
- sync_err  out  1  sticky: pix_first arrived mid-patch
- patch_count  out  16  number of patches handed off; wraps 65535 -> 0

## Operation
- Storage: two banks, bank[0] and bank[1], each PATCH_N x DATA_W. Each bank has a full flag.
- Pointers: wr_bank, wr_idx (0..PATCH_N-1), rd_bank.
- Accept: a beat is accepted when pix_valid && pix_ready.
  - pix_ready = !full[wr_bank] && !reset.
  - The signal is driven from registers only and has no combinational path from patch_ready or pix_valid.
- On an accepted beat without pix_first:
  - bank[wr_bank][wr_idx] <= pix_in.
  - If wr_idx == PATCH_N-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
  - Otherwise wr_idx increments.
- On an accepted beat with pix_first:
  - Pixel is written to index 0 of wr_bank, and wr_idx <= 1.
  - If wr_idx was not 0, the partial patch is discarded and sync_err <= 1.
  - If wr_idx was 0, this is normal behaviour and sync_err is not set.
- Output side:
  - patch_valid = full[rd_bank].
  - pixels_out = bank[rd_bank], driven directly from storage.
  - On patch_valid && patch_ready: full[rd_bank] <= 0, rd_bank toggles, patch_count increments.
- Simultaneous events: completing a fill into one bank and handing off the other bank in the same cycle both take effect. Flags are independent per bank.
- pixels_out is stable while patch_valid is high and patch_ready is low.
- sync_err stays set until reset.

## Timing
- Reset values (cycle after reset sampled high):
  - Outputs: patch_valid=0, pix_ready=0 while reset is high and 1 the first cycle after, sync_err=0, patch_count=0, pixels_out=0.
  - Internal state: both banks zeroed, both full flags 0, wr_bank=rd_bank=wr_idx=0.
- Reset mid-operation discards all partial and full patches.
- Latency: 36th pixel accepted in cycle N -> patch_valid=1 in cycle N+1.
- Throughput: with patch_ready held high, one patch per 36 accepted beats, and pix_ready never drops.
- Backpressure:
  - Both banks full -> pix_ready=0.
  - Handshake in cycle M -> pix_ready=1 in cycle M+1.
- patch_valid drops the cycle after a handshake unless the other bank is already full. In that case it stays high and pixels_out switches to the other bank in cycle M+1.
- pix_valid may toggle freely. Gaps stall wr_idx and do not corrupt the patch.

## Test plan
- Basic fill: after reset, stream pixels 0..35 with pix_first on the first beat and patch_ready=1. Required: patch_valid for exactly one cycle, 1 cycle after the last beat; pixels_out[k]=k; patch_count=1.
- Ping-pong under backpressure: hold patch_ready=0 and stream 72 pixels of values 100..171. Required:
  - pix_ready falls after beat 72; patch_valid=1 with pixels_out[0]=100.
  - Pulse patch_ready: next cycle pixels_out[0]=136 and patch_valid stays 1; pix_ready=1 next cycle.
  - Second pulse: patch_valid=0; patch_count=2.
- Simultaneous complete+drain: bank B completes in the same cycle that bank A is taken. Required: patch_valid stays 1 continuously, pixels_out switches to B, and no beat is lost.
- Resync: send 10 pixels, then pix_first with value 0xAAAA followed by 35 more pixels. Required: sync_err=1; the patch has pixels_out[0]=0xAAAA and contains only the last 36 pixels.
- Reset mid-fill: send 20 pixels, assert reset for 1 cycle, then send a full patch. Required: outputs at reset values after reset; the emitted patch contains only post-reset pixels; patch_count=1.
- Wrap: preload or run 65536 handoffs. Required: patch_count returns to 0 and the data path is unaffected.
